// File: rtl/interleaver_blk_ctrl_if.sv
// Handshake bundle between the interleaver block sequencer and the
// upstream byte source, the remap/index logic and the serial output stage.
interface interleaver_blk_ctrl_if;
    logic        start;
    logic        k_sel;
    logic        byte_valid;
    logic        abort;
    logic        byte_ready;
    logic        shift_en;
    logic        k_size_6144;
    logic        ready_out;
    logic [12:0] bit_idx;
    logic        last_bit;
    logic        busy;
    logic        done;

    modport master (
        output start, k_sel, byte_valid, abort,
        input  byte_ready, shift_en, k_size_6144, ready_out,
        input  bit_idx, last_bit, busy, done
    );

    modport slave (
        input  start, k_sel, byte_valid, abort,
        output byte_ready, shift_en, k_size_6144, ready_out,
        output bit_idx, last_bit, busy, done
    );
endinterface

// File: rtl/interleaver_blk_ctrl.sv
// Block sequencer for the turbo-coder interleaver: byte load, remap settle
// window, then a K-cycle bit-serial readout, one block at a time.
module interleaver_blk_ctrl #(
    parameter int K_SMALL       = 1056,
    parameter int K_LARGE       = 6144,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   rst,
    interleaver_blk_ctrl_if.slave  bus
);
    localparam logic [9:0]  BYTE_LAST_SMALL = 10'(K_SMALL / 8 - 1);
    localparam logic [9:0]  BYTE_LAST_LARGE = 10'(K_LARGE / 8 - 1);
    localparam logic [12:0] BIT_LAST_SMALL  = 13'(K_SMALL - 1);
    localparam logic [12:0] BIT_LAST_LARGE  = 13'(K_LARGE - 1);
    localparam logic [2:0]  SETTLE_LAST     = 3'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  settle_cnt_q, settle_cnt_d;
    logic [12:0] bit_idx_q, bit_idx_d;
    logic        k_size_q, k_size_d;

    logic [9:0]  byte_last;
    logic [12:0] bit_last;
    logic        shift_en;

    assign byte_last = k_size_q ? BYTE_LAST_LARGE : BYTE_LAST_SMALL;
    assign bit_last  = k_size_q ? BIT_LAST_LARGE  : BIT_LAST_SMALL;
    // The only input-to-output path: the datapath shifts in the same cycle the byte is offered.
    assign shift_en  = (state_q == S_LOAD) && bus.byte_valid;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            settle_cnt_q <= '0;
            bit_idx_q    <= '0;
            k_size_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            bit_idx_q    <= bit_idx_d;
            k_size_q     <= k_size_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        bit_idx_d    = bit_idx_q;
        k_size_d     = k_size_q;

        // Abort beats every other event, including the final byte or bit; block size is kept.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            byte_cnt_d   = '0;
            settle_cnt_d = '0;
            bit_idx_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        k_size_d   = bus.k_sel;
                        byte_cnt_d = '0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (shift_en) begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                        if (byte_cnt_q == byte_last) begin
                            settle_cnt_d = '0;
                            state_d      = S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        byte_cnt_d   = '0;
                        bit_idx_d    = '0;
                        state_d      = S_OUTPUT;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 3'd1;
                    end
                end
                S_OUTPUT: begin
                    if (bit_idx_q == bit_last) begin
                        bit_idx_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 13'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready  = (state_q == S_LOAD);
    assign bus.shift_en    = shift_en;
    assign bus.k_size_6144 = k_size_q;
    assign bus.ready_out   = (state_q == S_OUTPUT);
    assign bus.bit_idx     = bit_idx_q;
    assign bus.last_bit    = (state_q == S_OUTPUT) && (bit_idx_q == bit_last);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_interleaver_blk_ctrl.sv
// Directed bench for the interleaver block sequencer: two instances (settle
// window 1 and 3) driven from shared stimulus, one selected at a time.
module tb_interleaver_blk_ctrl;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    interleaver_blk_ctrl_if if1 ();
    interleaver_blk_ctrl_if if3 ();

    interleaver_blk_ctrl #(.K_SMALL(1056), .K_LARGE(6144), .SETTLE_CYCLES(1)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (if1.slave)
    );

    interleaver_blk_ctrl #(.K_SMALL(1056), .K_LARGE(6144), .SETTLE_CYCLES(3)) dut3 (
        .clock (clock),
        .rst   (rst),
        .bus   (if3.slave)
    );

    logic start_v = 1'b0, k_sel_v = 1'b0, bv_v = 1'b0, abort_v = 1'b0, use3 = 1'b0;

    assign if1.start      = start_v & ~use3;
    assign if1.k_sel      = k_sel_v;
    assign if1.byte_valid = bv_v & ~use3;
    assign if1.abort      = abort_v & ~use3;
    assign if3.start      = start_v & use3;
    assign if3.k_sel      = k_sel_v;
    assign if3.byte_valid = bv_v & use3;
    assign if3.abort      = abort_v & use3;

    wire        m_shift = use3 ? if3.shift_en    : if1.shift_en;
    wire        m_brdy  = use3 ? if3.byte_ready  : if1.byte_ready;
    wire        m_k     = use3 ? if3.k_size_6144 : if1.k_size_6144;
    wire        m_ready = use3 ? if3.ready_out   : if1.ready_out;
    wire [12:0] m_idx   = use3 ? if3.bit_idx     : if1.bit_idx;
    wire        m_last  = use3 ? if3.last_bit    : if1.last_bit;
    wire        m_busy  = use3 ? if3.busy        : if1.busy;
    wire        m_done  = use3 ? if3.done        : if1.done;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle monitor, sampled on the falling edge.
    int   cyc = 0, shift_cnt, load_cyc, ready_cnt, last_cnt, done_cnt, seq_err, k_err;
    int   last_shift_cyc, first_ready_cyc, exp_idx;
    logic exp_k = 1'b0;

    task automatic clear_mon();
        shift_cnt = 0; load_cyc = 0; ready_cnt = 0; last_cnt = 0; done_cnt = 0;
        seq_err = 0; k_err = 0; last_shift_cyc = 0; first_ready_cyc = -1; exp_idx = 0;
    endtask

    always @(negedge clock) begin
        int k_bits;
        k_bits = exp_k ? 6144 : 1056;
        cyc++;
        if (m_shift) begin
            shift_cnt++;
            last_shift_cyc = cyc;
        end
        if (m_shift && !m_brdy) seq_err++;
        if (m_brdy) load_cyc++;
        if (m_ready) begin
            if (first_ready_cyc < 0) first_ready_cyc = cyc;
            ready_cnt++;
            if (int'(m_idx) != exp_idx) seq_err++;
            if (m_last != (exp_idx == k_bits - 1)) seq_err++;
            exp_idx++;
        end else begin
            exp_idx = 0;
            if (m_idx != 13'd0 || m_last) seq_err++;
        end
        if (m_last) last_cnt++;
        if (m_done) done_cnt++;
        if (m_busy && (m_k != exp_k)) k_err++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_block(input logic k);
        clear_mon();
        exp_k   = k;
        k_sel_v = k;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
    endtask

    task automatic feed_bytes(input logic toggle, input logic disturb, input logic k);
        int g = 0;
        while (m_brdy && g < 4000) begin
            bv_v = toggle ? (g % 2 == 0) : 1'b1;
            if (disturb && g == 10) begin
                start_v = 1'b1;
                k_sel_v = ~k;
            end else begin
                start_v = 1'b0;
            end
            tick();
            g++;
        end
        bv_v    = 1'b0;
        start_v = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic k, input logic toggle,
                             input logic disturb, input int exp_gap);
        int g = 0;
        int k_bits;
        k_bits = k ? 6144 : 1056;
        begin_block(k);
        feed_bytes(toggle, disturb, k);
        while (!m_done && g < 10000) begin
            start_v = (disturb && g == 300);
            if (disturb && g == 300) k_sel_v = ~k;
            tick();
            g++;
        end
        start_v = 1'b0;
        chk({tag, "_done_seen"}, 32'(m_done), 32'd1);
        tick();
        chk({tag, "_busy_after"}, 32'(m_busy), 32'd0);
        chk({tag, "_done_width"}, 32'(m_done), 32'd0);
        chk({tag, "_shift_cnt"}, 32'(shift_cnt), 32'(k_bits / 8));
        chk({tag, "_ready_cnt"}, 32'(ready_cnt), 32'(k_bits));
        chk({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_k_err"}, 32'(k_err), 32'd0);
        chk({tag, "_settle_gap"}, 32'(first_ready_cyc - last_shift_cyc - 1), 32'(exp_gap));
        $display("block %s: K=%0d bytes=%0d bits=%0d load_cycles=%0d", tag, k_bits,
                 shift_cnt, ready_cnt, load_cyc);
    endtask

    initial begin
        int g;
        clear_mon();
        #12;
        chk("rst_busy", 32'(if1.busy), 32'd0);
        chk("rst_ready_out", 32'(if1.ready_out), 32'd0);
        chk("rst_bit_idx", 32'(if1.bit_idx), 32'd0);
        chk("rst_k_size", 32'(if1.k_size_6144), 32'd0);
        chk("rst_byte_ready", 32'(if1.byte_ready), 32'd0);
        chk("rst_done", 32'(if1.done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // byte_valid in IDLE must not shift
        bv_v = 1'b1;
        #1;
        chk("idle_shift_en", 32'(if1.shift_en), 32'd0);
        tick();
        chk("idle_busy", 32'(if1.busy), 32'd0);
        bv_v = 1'b0;

        run_block("t1_small", 1'b0, 1'b0, 1'b0, 1);

        run_block("t2_large_toggle", 1'b1, 1'b1, 1'b0, 1);
        chk("t2_load_cycles", 32'(load_cyc), 32'd1535);
        chk("t2_k_held", 32'(if1.k_size_6144), 32'd1);

        // abort on the 50th byte of a large block
        begin_block(1'b1);
        bv_v = 1'b1;
        repeat (49) tick();
        abort_v = 1'b1;
        tick();
        abort_v = 1'b0;
        bv_v    = 1'b0;
        chk("t3_busy_after_abort", 32'(if1.busy), 32'd0);
        chk("t3_byte_ready_after_abort", 32'(if1.byte_ready), 32'd0);
        chk("t3_k_hold_after_abort", 32'(if1.k_size_6144), 32'd1);
        repeat (20) tick();
        chk("t3_bytes_before_abort", 32'(shift_cnt), 32'd50);
        chk("t3_no_ready_out", 32'(ready_cnt), 32'd0);
        chk("t3_no_done", 32'(done_cnt), 32'd0);
        $display("block t3_abort: aborted after %0d bytes", shift_cnt);
        run_block("t3_after_abort", 1'b0, 1'b0, 1'b0, 1);

        run_block("t4_disturb", 1'b0, 1'b0, 1'b1, 1);

        // asynchronous reset in the middle of the readout
        begin_block(1'b1);
        feed_bytes(1'b0, 1'b0, 1'b1);
        g = 0;
        while (if1.bit_idx != 13'd500 && g < 2000) begin
            tick();
            g++;
        end
        chk("t5_reached_bit500", 32'(if1.bit_idx), 32'd500);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_ready_out", 32'(if1.ready_out), 32'd0);
        chk("t5_async_busy", 32'(if1.busy), 32'd0);
        chk("t5_async_bit_idx", 32'(if1.bit_idx), 32'd0);
        chk("t5_async_k_size", 32'(if1.k_size_6144), 32'd0);
        $display("block t5_async_rst: reset applied at bit 500");
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_block("t5_after_rst", 1'b0, 1'b0, 1'b0, 1);

        // wider settle window instance; start with abort is refused
        use3 = 1'b1;
        tick();
        start_v = 1'b1;
        abort_v = 1'b1;
        tick();
        start_v = 1'b0;
        abort_v = 1'b0;
        chk("t6_start_abort_idle", 32'(if3.busy), 32'd0);
        $display("block t6_start_abort: stayed idle");
        run_block("t6_settle3", 1'b0, 1'b0, 1'b0, 3);
        use3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/interleaver_blk_ctrl.md
Name: interleaver_blk_ctrl

Overview:
Block-level sequencer for the turbo-coder interleaver datapath (byte shift register, QPP remap, bit-serial output muxes).
- Latches the block size at start and gates byte loading into the shift register.
- Inserts a settle window for the combinational remap.
- Drives the K-cycle serial readout handshake.
- Handles one block at a time, matching the single turbo-coder pair.

Parameters:
K_SMALL, 1056, small block size in bits (132 bytes)
K_LARGE, 6144, large block size in bits (768 bytes)
SETTLE_CYCLES, 1, idle cycles between last byte loaded and first output bit (range 1..4)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a block; sampled only in IDLE
k_sel  in  1  block size with start: 0 = K_SMALL, 1 = K_LARGE
byte_valid  in  1  upstream byte present on the datapath byte input
abort  in  1  synchronous abort; returns to IDLE
byte_ready  out  1  controller accepts bytes (high in LOAD)
shift_en  out  1  shift-register enable, combinational = byte_valid & byte_ready
k_size_6144  out  1  latched block size to remap and index logic
ready_out  out  1  serial output phase active, high for exactly K cycles
bit_idx  out  13  output bit index 0..K-1 during OUTPUT, 0 otherwise
last_bit  out  1  high on the cycle bit_idx == K-1 in OUTPUT
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last bit

Behaviour:
Reset values:
- rst asserted: state = IDLE; all counters 0; every output 0, including k_size_6144.
- rst asynchronously overrides any state mid-block.

State machine (states IDLE, LOAD, SETTLE, OUTPUT, DONE):
- IDLE: start=1 & abort=0 → latch k_size_6144 <= k_sel, clear byte_cnt, go to LOAD. start in any other state is ignored.
- LOAD: byte_ready=1. Each edge with shift_en=1 increments byte_cnt (10-bit).
  - The edge accepting byte number K/8 (132 or 768) moves to SETTLE. byte_cnt never exceeds K/8.
  - Gaps in byte_valid stall; there is no timeout.
- SETTLE: byte_ready=0. Stays exactly SETTLE_CYCLES cycles (settle counter), then goes to OUTPUT with bit_idx=0.
- OUTPUT: ready_out=1; bit_idx increments by 1 per cycle. last_bit is high when bit_idx == K-1. The next edge goes to DONE.
- DONE: done=1 for one cycle, ready_out=0, bit_idx=0. Then IDLE. A start in DONE is ignored; the earliest new start is accepted in IDLE.

Rules:
- abort (any state except IDLE): next state IDLE, counters cleared. k_size_6144 holds its value. No done pulse.
- abort with start in IDLE: abort wins; stay in IDLE.
- abort in the same cycle as the final byte or last_bit: abort wins.
- shift_en is 0 outside LOAD regardless of byte_valid.
- k_size_6144 is stable from LOAD through DONE. k_sel is ignored after the start cycle.
- Latency with back-to-back bytes, start edge to done pulse: 1 + K/8 + SETTLE_CYCLES + K + 1 cycles.
  - K_SMALL, SETTLE=1: 1191 cycles.
  - K_LARGE, SETTLE=1: 6915 cycles.
- All outputs except shift_en are registered or decoded directly from state/counter registers. There are no combinational paths from inputs to outputs other than shift_en.

Test Plan:
1. Reset, start with k_sel=0, byte_valid held 1 → shift_en high exactly 132 cycles; SETTLE for 1 cycle; ready_out high exactly 1056 cycles with bit_idx 0..1055; last_bit at 1055; done pulse; busy falls the next cycle.
2. start with k_sel=1, byte_valid toggling every other cycle → exactly 768 shift_en pulses over about 1536 cycles; ready_out high exactly 6144 cycles; k_size_6144=1 throughout.
3. abort asserted at the 50th accepted byte → IDLE the next cycle; no ready_out, no done; a new start with k_sel=0 then completes a normal 1056-bit block.
4. start pulsed during LOAD and during OUTPUT, and k_sel flipped mid-block → ignored; byte count and bit count unchanged; k_size_6144 unchanged.
5. rst asserted asynchronously mid-OUTPUT (bit_idx≈500) → all outputs 0 immediately without waiting for a clock edge; the next start runs cleanly. Also: byte_valid=1 in IDLE → shift_en stays 0.
6. SETTLE_CYCLES=3, start and abort together in IDLE → stays IDLE. A following plain start shows a 3-cycle gap between the last shift_en and the first ready_out.
